// File: rtl/led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// led_seq_ctrl
//
// Four-mode LED sequencer driven by two debounced key pulses.
//   IDLE  : everything dark, position parked at 0.
//   STEP  : each key_step moves the position forward by one.
//   AUTO  : the position advances once per tick interval; key_step
//           freezes or unfreezes the run.
//   BLINK : the whole bar flashes on and off once per tick interval.
// key_mode cycles IDLE -> STEP -> AUTO -> BLINK -> IDLE. If key_mode and
// key_step arrive in the same cycle, key_mode wins.
//
// Parameters
//   TICK_DIV : tick interval in clk cycles (2 or more)
//   POS_MAX  : last sequence position (1..9); the position wraps to 0 after it
//
// Ports
//   clk      : system clock, all state changes on its rising edge
//   rst      : synchronous, active-high reset
//   key_step : one-cycle step / pause-toggle request
//   key_mode : one-cycle mode-advance request
//   led      : registered LED drive
//   mode     : current mode (IDLE=0, STEP=1, AUTO=2, BLINK=3)
//   pos      : current sequence position
//   paused   : high while an AUTO run is frozen
// -----------------------------------------------------------------------------
module led_seq_ctrl #(
  parameter int TICK_DIV = 25_000_000,
  parameter int POS_MAX  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_step,
  input  logic       key_mode,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [3:0] pos,
  output logic       paused
);

  // Tick counter runs 0..TICK_DIV-1, so ceil(log2(TICK_DIV)) bits suffice.
  localparam int               CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       POS_LAST = 4'(POS_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_AUTO  = 2'd2,
    S_BLINK = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       pos_nxt;
  logic [7:0]       led_nxt;
  logic             paused_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_active;
  logic             tick;

  // Next position with wrap after the last position. Using >= keeps the
  // position inside the legal range even if it were ever corrupted.
  function automatic logic [3:0] pos_advance(input logic [3:0] p);
    return (p >= POS_LAST) ? 4'd0 : p + 4'd1;
  endfunction

  // Position-to-LED decode: 0 is dark, 1..8 light a single LED, 9 lights all.
  function automatic logic [7:0] pos_decode(input logic [3:0] p);
    logic [7:0] d;
    d = 8'h00;
    if (p == 4'd9) begin
      d = 8'hFF;
    end else if ((p >= 4'd1) && (p <= 4'd8)) begin
      d = 8'h01 << (p - 4'd1);
    end
    return d;
  endfunction

  // The tick counter only runs while an AUTO run is live or while blinking.
  assign cnt_active = ((state == S_AUTO) && !paused) || (state == S_BLINK);
  assign tick       = cnt_active && (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // through the case statements can leave it unassigned and infer a latch.
    state_nxt  = state;
    pos_nxt    = pos;
    paused_nxt = paused;
    cnt_nxt    = cnt;
    led_nxt    = pos_decode(pos);

    if (key_mode) begin
      // Mode change: any key_step in the same cycle is dropped, the tick
      // counter restarts and a frozen run is released.
      cnt_nxt    = '0;
      paused_nxt = 1'b0;
      unique case (state)
        S_IDLE: begin
          state_nxt = S_STEP;
          pos_nxt   = 4'd0;
          led_nxt   = 8'h00;
        end
        S_STEP: begin
          state_nxt = S_AUTO;
          led_nxt   = pos_decode(pos);
        end
        S_AUTO: begin
          state_nxt = S_BLINK;
          led_nxt   = 8'hFF;
        end
        S_BLINK: begin
          state_nxt = S_IDLE;
          pos_nxt   = 4'd0;
          led_nxt   = 8'h00;
        end
        default: begin
          state_nxt = S_IDLE;
          pos_nxt   = 4'd0;
          led_nxt   = 8'h00;
        end
      endcase
    end else begin
      unique case (state)
        S_IDLE: begin
          pos_nxt    = 4'd0;
          paused_nxt = 1'b0;
          cnt_nxt    = '0;
          led_nxt    = 8'h00;
        end
        S_STEP: begin
          if (key_step) begin
            pos_nxt = pos_advance(pos);
          end
          led_nxt = pos_decode(pos_nxt);
        end
        S_AUTO: begin
          if (key_step) begin
            // A pause toggle swallows a coincident tick and holds the count,
            // so counting picks up from the same value after unpausing.
            paused_nxt = !paused;
          end else if (cnt_active) begin
            if (tick) begin
              cnt_nxt = '0;
              pos_nxt = pos_advance(pos);
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
          led_nxt = pos_decode(pos_nxt);
        end
        S_BLINK: begin
          // Blinking flips the whole bar on each tick; the position is
          // frozen and key_step has no meaning here.
          if (tick) begin
            cnt_nxt = '0;
            led_nxt = ~led;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
            led_nxt = led;
          end
        end
        default: begin
          state_nxt  = S_IDLE;
          pos_nxt    = 4'd0;
          paused_nxt = 1'b0;
          cnt_nxt    = '0;
          led_nxt    = 8'h00;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // values from before this edge, regardless of statement order.
    if (rst) begin
      state  <= S_IDLE;
      pos    <= 4'd0;
      led    <= 8'h00;
      paused <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      led    <= led_nxt;
      paused <= paused_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign mode = state;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    cnt <= CNT_LAST);

  a_pos_range : assert property (@(posedge clk) disable iff (rst)
    pos <= POS_LAST);

  a_led_decode : assert property (@(posedge clk) disable iff (rst)
    (state != S_BLINK) |-> (led == pos_decode(pos)));

  a_blink_levels : assert property (@(posedge clk) disable iff (rst)
    (state == S_BLINK) |-> ((led == 8'hFF) || (led == 8'h00)));

endmodule
